// File: rtl/calculadora_param.sv
`timescale 1ns/1ps
// calculadora_param: keypad-driven four-function decimal calculator.
// Operands are typed digit by digit, the result is computed (multiply and
// divide iteratively, one bit per cycle) and streamed out digit by digit.
module calculadora_param #(
  parameter int N_DIG = 8,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               cmd,
  input  logic                     cmd_valid,
  output logic [1:0]               status,
  output logic [3:0]               dig,
  output logic [$clog2(N_DIG)-1:0] pos,
  output logic                     dig_valid,
  output logic                     neg
);

  localparam int PW = $clog2(N_DIG);
  localparam int CW = $clog2(W) + 1;
  localparam int RW = 2 * W;

  function automatic logic [RW-1:0] pow10(input int n);
    logic [RW-1:0] p;
    p = RW'(1);
    for (int i = 0; i < n; i++) p = p * RW'(10);
    return p;
  endfunction

  // Largest displayable result, and largest operand that still takes a digit.
  localparam logic [RW-1:0] MAX_R   = pow10(N_DIG) - RW'(1);
  localparam logic [W-1:0]  OPD_CAP = W'(pow10(N_DIG - 1) - RW'(1));

  localparam logic [2:0] S_IN_A  = 3'd0;
  localparam logic [2:0] S_IN_OP = 3'd1;
  localparam logic [2:0] S_IN_B  = 3'd2;
  localparam logic [2:0] S_IN_EQ = 3'd3;
  localparam logic [2:0] S_CALC  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [1:0] ST_ERRO    = 2'd0;
  localparam logic [1:0] ST_PRONTA  = 2'd1;
  localparam logic [1:0] ST_OCUPADA = 2'd2;
  localparam logic [1:0] ST_IMPRIME = 2'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [3:0] K_ADD  = 4'd10;
  localparam logic [3:0] K_DIV  = 4'd13;
  localparam logic [3:0] K_EQ   = 4'd14;
  localparam logic [3:0] K_BACK = 4'd15;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [RW-1:0] r_q, r_d;     // result; accumulator while multiplying
  logic [RW-1:0] w_q, w_d;     // shifted multiplicand, or division remainder
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d; // CALC iteration / SEND digit index
  logic          neg_q, neg_d;
  logic          echo_q, echo_d;
  logic [3:0]    echo_dig_q, echo_dig_d;

  logic          is_digit, is_op, last_iter, calc_done, ge;
  logic [W:0]    trial;
  logic [RW-1:0] r_fin;

  assign is_digit  = (cmd <= 4'd9);
  assign is_op     = (cmd >= K_ADD) && (cmd <= K_DIV);
  assign last_iter = (cnt_q == CW'(W - 1));

  // Next-state logic for the key-entry, compute and print sequence.
  always_comb begin
    // NOTE: every signal written here gets a hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    w_d        = w_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    echo_d     = 1'b0;
    echo_dig_d = echo_dig_q;
    r_fin      = r_q;
    calc_done  = 1'b0;
    trial      = {w_q[W-1:0], a_q[W-1]};
    ge         = (trial >= {1'b0, b_q});

    case (state_q)
      S_IN_A: if (cmd_valid && is_digit) begin
        a_d        = W'(cmd);
        neg_d      = 1'b0;
        echo_d     = 1'b1;
        echo_dig_d = cmd;
        state_d    = S_IN_OP;
      end
      S_IN_OP: if (cmd_valid) begin
        if (is_digit) begin
          if (a_q <= OPD_CAP) begin
            a_d        = a_q * W'(10) + W'(cmd);
            echo_d     = 1'b1;
            echo_dig_d = cmd;
          end
        end else if (cmd == K_BACK) begin
          a_d = a_q / W'(10);
        end else if (is_op) begin
          op_d    = 2'(cmd - K_ADD);
          state_d = S_IN_B;
        end
      end
      S_IN_B: if (cmd_valid && is_digit) begin
        b_d        = W'(cmd);
        echo_d     = 1'b1;
        echo_dig_d = cmd;
        state_d    = S_IN_EQ;
      end
      S_IN_EQ: if (cmd_valid) begin
        if (is_digit) begin
          if (b_q <= OPD_CAP) begin
            b_d        = b_q * W'(10) + W'(cmd);
            echo_d     = 1'b1;
            echo_dig_d = cmd;
          end
        end else if (cmd == K_BACK) begin
          b_d = b_q / W'(10);
        end else if (cmd == K_EQ) begin
          cnt_d   = '0;
          r_d     = '0;
          w_d     = (op_q == OP_DIV) ? '0 : RW'(a_q);
          state_d = S_CALC;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        case (op_q)
          OP_ADD: begin
            r_fin     = RW'(a_q) + RW'(b_q);
            calc_done = 1'b1;
          end
          OP_SUB: begin
            neg_d     = (b_q > a_q);
            r_fin     = (b_q > a_q) ? RW'(b_q - a_q) : RW'(a_q - b_q);
            calc_done = 1'b1;
          end
          OP_MUL: begin
            // Multiplier bits consumed LSB first from b; multiplicand doubles each step.
            r_fin     = b_q[0] ? r_q + w_q : r_q;
            r_d       = r_fin;
            w_d       = w_q << 1;
            b_d       = b_q >> 1;
            calc_done = last_iter;
          end
          default: begin
            // Restoring division: dividend shifts out of a, quotient bits shift in.
            w_d       = RW'(ge ? trial - {1'b0, b_q} : trial);
            a_d       = {a_q[W-2:0], ge};
            r_fin     = RW'({a_q[W-2:0], ge});
            r_d       = r_fin;
            calc_done = last_iter;
          end
        endcase
        if (op_q == OP_DIV && b_q == '0) begin
          cnt_d   = '0;
          state_d = S_ERROR;
        end else if (calc_done) begin
          cnt_d   = '0;
          r_d     = r_fin;
          state_d = (r_fin > MAX_R) ? S_ERROR : S_SEND;
        end
      end
      S_SEND: begin
        r_d   = RW'(r_q[W-1:0] / W'(10));
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N_DIG - 1)) begin
          cnt_d   = '0;
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_ADD;
          state_d = S_IN_A;
        end
      end
      S_ERROR: if (cmd_valid && cmd == K_EQ) begin
        a_d     = '0;
        b_d     = '0;
        r_d     = '0;
        w_d     = '0;
        op_d    = OP_ADD;
        neg_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_IN_A;
      end
      default: state_d = S_IN_A;
    endcase
  end

  // State registers; reset clears everything and aborts any computation or print.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IN_A;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      w_q        <= '0;
      op_q       <= OP_ADD;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      echo_q     <= 1'b0;
      echo_dig_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      w_q        <= w_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      echo_q     <= echo_d;
      echo_dig_q <= echo_dig_d;
    end
  end

  // Status follows the state; digit outputs show either the echo or the SEND digit.
  always_comb begin
    case (state_q)
      S_IN_A:  status = ST_PRONTA;
      S_SEND:  status = ST_IMPRIME;
      S_ERROR: status = ST_ERRO;
      default: status = ST_OCUPADA;
    endcase
  end

  assign dig_valid = echo_q || (state_q == S_SEND);
  assign dig       = (state_q == S_SEND) ? 4'(r_q[W-1:0] % W'(10)) : echo_dig_q;
  assign pos       = (state_q == S_SEND) ? PW'(cnt_q) : '0;
  assign neg       = neg_q;

endmodule
